// File: rtl/pwm_fader.sv
// Brightness fader for a downstream PWM: generates the PWM tick and steps the
// duty value toward a requested goal once every STEP_PERIODS PWM periods.
module pwm_fader #(
    parameter int MAX_VALUE    = 1000,
    parameter int BITS         = 10,
    parameter int TICK_DIV     = 50,
    parameter int STEP_PERIODS = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [BITS-1:0] target,
    input  logic [BITS-1:0] step,
    input  logic            instant,
    input  logic            target_valid,
    output logic            target_ready,
    output logic            tick,
    output logic [BITS-1:0] value,
    output logic            busy
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PER_W = (MAX_VALUE > 1) ? $clog2(MAX_VALUE) : 1;
    localparam int STP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(MAX_VALUE - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(STEP_PERIODS - 1);
    localparam logic [BITS:0]    MAXV     = (BITS+1)'(MAX_VALUE);

    typedef enum logic {IDLE, FADE} state_t;

    state_t          r_state;
    logic [DIV_W-1:0] r_div;
    logic [PER_W-1:0] r_per;
    logic [STP_W-1:0] r_stp;
    logic            r_tick;
    logic            r_ready;
    logic            r_busy;
    logic [BITS-1:0] r_value;
    logic [BITS-1:0] r_goal;
    logic [BITS-1:0] r_step;

    logic            w_period_end;
    logic            w_step_strobe;
    logic            w_accept;
    logic [BITS-1:0] w_goal;
    logic [BITS-1:0] w_step;
    logic [BITS:0]   w_val_ext;
    logic [BITS:0]   w_goal_ext;
    logic [BITS:0]   w_step_ext;
    logic [BITS:0]   w_sum;
    logic [BITS:0]   w_diff;
    logic [BITS-1:0] w_next;

    // Tick divider, PWM period counter and fade-step counter, all free-running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
            r_per  <= '0;
            r_stp  <= '0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            if (r_tick)
                r_per <= (r_per == PER_LAST) ? '0 : r_per + PER_W'(1);
            if (w_period_end)
                r_stp <= (r_stp == STP_LAST) ? '0 : r_stp + STP_W'(1);
        end
    end

    assign w_period_end  = r_tick && (r_per == PER_LAST);
    assign w_step_strobe = w_period_end && (r_stp == STP_LAST);
    assign w_accept      = target_valid && r_ready;
    assign w_goal        = ({1'b0, target} > MAXV) ? MAXV[BITS-1:0] : target;
    assign w_step        = (step == '0) ? BITS'(1) : step;

    // One fade step at BITS+1 width so it can neither wrap nor overshoot the goal.
    always_comb begin
        w_val_ext  = {1'b0, r_value};
        w_goal_ext = {1'b0, r_goal};
        w_step_ext = {1'b0, r_step};
        w_sum      = w_val_ext + w_step_ext;
        w_diff     = w_val_ext - w_step_ext;
        w_next     = r_goal;
        if (w_goal_ext > w_val_ext) begin
            if (w_sum < w_goal_ext)
                w_next = w_sum[BITS-1:0];
        end else begin
            if (w_val_ext > w_goal_ext + w_step_ext)
                w_next = w_diff[BITS-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_value <= '0;
            r_goal  <= '0;
            r_step  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_goal <= w_goal;
                        r_step <= w_step;
                        if (instant) begin
                            r_value <= w_goal;
                        end else if (w_goal != r_value) begin
                            r_state <= FADE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                FADE: begin
                    if (w_step_strobe) begin
                        r_value <= w_next;
                        if (w_next == r_goal) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign target_ready = r_ready;
    assign tick         = r_tick;
    assign value        = r_value;
    assign busy         = r_busy;

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL provide parameter MAX_VALUE, default 1000, PWM period length in ticks.
REQ-002 SHALL provide parameter BITS, default 10, width of value, target and step.
REQ-003 SHALL provide parameter TICK_DIV, default 50, clocks per tick (legal range 2 or more).
REQ-004 SHALL provide parameter STEP_PERIODS, default 4, PWM periods per fade step (legal range 1 or more).
REQ-005 SHALL provide port clock, input, 1 bit, the single clock; every register is clocked on its rising edge.
REQ-006 SHALL provide port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL provide port target, input, BITS bits, requested brightness.
REQ-008 SHALL provide port step, input, BITS bits, brightness change per fade step; sampled with target.
REQ-009 SHALL provide port instant, input, 1 bit; when high at acceptance, the fade is skipped.
REQ-010 SHALL provide port target_valid, input, 1 bit, request strobe.
REQ-011 SHALL provide port target_ready, output, 1 bit, high only in IDLE.
REQ-012 SHALL provide port tick, output, 1 bit, registered one-clock pulse that drives the downstream PWM tick.
REQ-013 SHALL provide port value, output, BITS bits, registered duty value that drives the downstream PWM value.
REQ-014 SHALL provide port busy, output, 1 bit, high in FADE.

Function
REQ-015 SHALL pulse tick high for exactly one clock every TICK_DIV clocks, free-running, independent of state; first tick on the TICK_DIV-th rising edge after reset_n deasserts.
REQ-016 SHALL keep a period counter that counts ticks 0..MAX_VALUE-1 and wraps to 0; period_end = tick AND counter == MAX_VALUE-1, so it stays phase-aligned with a downstream PWM reset at the same time.
REQ-017 SHALL count period_end events 0..STEP_PERIODS-1, wrapping to 0; step_strobe = period_end AND that count == STEP_PERIODS-1.
REQ-018 SHALL define acceptance as target_valid AND target_ready on a rising edge.
REQ-019 SHALL clamp the accepted target to MAX_VALUE when target > MAX_VALUE; the result is the internal goal.
REQ-020 SHALL treat step == 0 as 1.
REQ-021 SHALL use state IDLE: target_ready=1, busy=0.
REQ-022 SHALL, in IDLE, on acceptance with instant=1, load value <= goal on the next edge and remain in IDLE.
REQ-023 SHALL, in IDLE, on acceptance with instant=0 and goal == value, remain in IDLE with value unchanged.
REQ-024 SHALL, in IDLE, on acceptance with instant=0 and goal != value, go to FADE on the next edge with target_ready=0 from that edge.
REQ-025 SHALL, in FADE, ignore target_valid.
REQ-026 SHALL, in FADE, update value only on the edge where step_strobe is high.
REQ-027 SHALL, on each such FADE update, move value toward goal by step, saturating exactly at goal with no overshoot, computed at BITS+1 width with no wrap below 0 or above MAX_VALUE.
REQ-028 SHALL return from FADE to IDLE on the same edge on which value becomes equal to goal.
REQ-029 SHALL make value change only at period boundaries during a fade; the instant load is the only mid-period change.

Reset
REQ-030 SHALL, while reset_n is low, asynchronously force tick=0, value=0, busy=0, target_ready=0, state=IDLE, goal=0, and all counters to 0.
REQ-031 SHALL drive target_ready=1 on the first edge after reset_n deasserts.
REQ-032 SHALL, on reset mid-fade, abandon the fade with no resume.

Verification (bench parameters MAX_VALUE=10, BITS=4, TICK_DIV=2, STEP_PERIODS=1)
REQ-033 SHALL cover: release reset -> tick at clocks 2,4,6,...; value=0; target_ready=1; busy=0.
REQ-034 SHALL cover: accept target=7, step=3, instant=0 -> busy=1; value 3, 6, 7 on three successive period_end edges (every 20 clocks); busy=0 with the final update.
REQ-035 SHALL cover: from value=7, accept target=0, step=5 -> value 2 then 0, no underflow; returns to IDLE.
REQ-036 SHALL cover: accept target=15, instant=1 -> value=10 (clamped) on the next edge; busy stays 0.
REQ-037 SHALL cover: during a fade, assert target_valid=1, target=1 -> ignored; target_ready=0; original goal reached.
REQ-038 SHALL cover: assert reset_n=0 mid-fade at value=3 -> immediately value=0, busy=0, tick=0; after release, behaviour as in REQ-033.
